// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR arbiter: FSM state encoding,
// default widths and the source identifiers used by the round-robin picker.
package ddr_arb_pkg;

    localparam int unsigned IDX_W_DEFAULT  = 19;
    localparam int unsigned LINE_W_DEFAULT = 512;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    localparam logic SRC_LSU = 1'b0;
    localparam logic SRC_IC  = 1'b1;

endpackage

// File: rtl/ddr_rr_pick.sv
// Two-way round-robin picker between the LSU and icache requesters.
// The last-grant pointer starts on the icache so the LSU wins the first tie.
module ddr_rr_pick
    import ddr_arb_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_ls_i,
    input  logic req_ic_i,
    input  logic take_i,
    output logic valid_o,
    output logic src_o
);

    logic last_q, last_d;

    always_comb begin
        valid_o = req_ls_i | req_ic_i;
        src_o   = SRC_LSU;
        if (req_ls_i && req_ic_i) begin
            src_o = (last_q == SRC_IC) ? SRC_LSU : SRC_IC;
        end else if (req_ic_i) begin
            src_o = SRC_IC;
        end
        last_d = last_q;
        if (take_i && valid_o) begin
            last_d = src_o;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= SRC_IC;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates a single DDR port between icache line fetches and LSU accesses,
// with redirect cancellation of icache fetches.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned IDX_W  = IDX_W_DEFAULT,
    parameter int unsigned LINE_W = LINE_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ic_read_req,
    input  logic [IDX_W-1:0]  ic_read_index,
    input  logic              redirect_valid,
    output logic              ic_read_done,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [IDX_W-1:0]  ls_index,
    input  logic [63:0]       ls_wmask,
    input  logic [63:0]       ls_wdata,
    output logic              ls_done,
    output logic [63:0]       ls_rdata,
    output logic              ddr_chip_enable,
    output logic [IDX_W-1:0]  ddr_index,
    output logic              ddr_write_enable,
    output logic              ddr_burst_mode,
    output logic [63:0]       ddr_opstore_write_mask,
    output logic [63:0]       ddr_opstore_write_data,
    input  logic [63:0]       ddr_opload_read_data,
    input  logic [LINE_W-1:0] ddr_pc_read_inst,
    input  logic              ddr_operation_done,
    input  logic              ddr_ready
);

    arb_state_e        state_q, state_d;
    logic              gnt_src_q, gnt_src_d;
    logic              cancel_q, cancel_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic              burst_q, burst_d;
    logic [63:0]       mask_q, mask_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_data_q, ic_data_d;
    logic [63:0]       ls_rdata_q, ls_rdata_d;

    logic ic_eligible;
    logic pick_valid;
    logic pick_src;
    logic grant;

    // A redirect in the same cycle as the request hides the icache from the picker.
    assign ic_eligible = ic_read_req & ~redirect_valid;
    assign grant       = (state_q == StIdle) & pick_valid & ddr_ready;

    ddr_rr_pick u_rr_pick (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_ls_i (ls_req),
        .req_ic_i (ic_eligible),
        .take_i   (grant),
        .valid_o  (pick_valid),
        .src_o    (pick_src)
    );

    always_comb begin
        state_d    = state_q;
        gnt_src_d  = gnt_src_q;
        cancel_d   = cancel_q;
        idx_d      = idx_q;
        we_d       = we_q;
        burst_d    = burst_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        ic_data_d  = ic_data_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d   = StIssue;
                    gnt_src_d = pick_src;
                    cancel_d  = 1'b0;
                    if (pick_src == SRC_IC) begin
                        idx_d   = ic_read_index;
                        we_d    = 1'b0;
                        burst_d = 1'b1;
                        mask_d  = '0;
                        wdata_d = '0;
                    end else begin
                        idx_d   = ls_index;
                        we_d    = ls_write;
                        burst_d = 1'b0;
                        mask_d  = ls_wmask;
                        wdata_d = ls_wdata;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                if (gnt_src_q == SRC_IC && redirect_valid) begin
                    cancel_d = 1'b1;
                end
            end
            StWait: begin
                if (gnt_src_q == SRC_IC && redirect_valid) begin
                    cancel_d = 1'b1;
                end
                if (ddr_operation_done) begin
                    state_d = StResp;
                    if (gnt_src_q == SRC_IC) begin
                        if (!cancel_d) begin
                            ic_data_d = ddr_pc_read_inst;
                        end
                    end else if (!we_q) begin
                        ls_rdata_d = ddr_opload_read_data;
                    end
                end
            end
            StResp: begin
                state_d  = StIdle;
                cancel_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            gnt_src_q  <= SRC_LSU;
            cancel_q   <= 1'b0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            burst_q    <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            ic_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_src_q  <= gnt_src_d;
            cancel_q   <= cancel_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            burst_q    <= burst_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            ic_data_q  <= ic_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign ddr_chip_enable        = (state_q == StIssue);
    assign ic_read_done           = (state_q == StResp) && (gnt_src_q == SRC_IC) && !cancel_q;
    assign ls_done                = (state_q == StResp) && (gnt_src_q == SRC_LSU);
    assign ic_read_data           = ic_data_q;
    assign ls_rdata               = ls_rdata_q;
    assign ddr_index              = idx_q;
    assign ddr_write_enable       = we_q;
    assign ddr_burst_mode         = burst_q;
    assign ddr_opstore_write_mask = mask_q;
    assign ddr_opstore_write_data = wdata_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Randomised bench for ddr_arbiter: a DDR responder with its own memory plus a
// reference memory and round-robin order predictor that set every expectation.
`timescale 1ns/1ps
module tb_ddr_arbiter;

    localparam int unsigned IW = 19;
    localparam int unsigned LW = 512;
    localparam bit SRC_L = 1'b0;
    localparam bit SRC_I = 1'b1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          we;
        logic          burst;
        logic [63:0]   mask;
        logic [63:0]   wdata;
    } cmd_t;

    logic          clock;
    logic          reset_n;
    logic          ic_read_req;
    logic [IW-1:0] ic_read_index;
    logic          redirect_valid;
    logic          ic_read_done;
    logic [LW-1:0] ic_read_data;
    logic          ls_req;
    logic          ls_write;
    logic [IW-1:0] ls_index;
    logic [63:0]   ls_wmask;
    logic [63:0]   ls_wdata;
    logic          ls_done;
    logic [63:0]   ls_rdata;
    logic          ddr_chip_enable;
    logic [IW-1:0] ddr_index;
    logic          ddr_write_enable;
    logic          ddr_burst_mode;
    logic [63:0]   ddr_opstore_write_mask;
    logic [63:0]   ddr_opstore_write_data;
    logic [63:0]   ddr_opload_read_data;
    logic [LW-1:0] ddr_pc_read_inst;
    logic          ddr_operation_done;
    logic          ddr_ready;

    ddr_arbiter #(.IDX_W(IW), .LINE_W(LW)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .ic_read_req            (ic_read_req),
        .ic_read_index          (ic_read_index),
        .redirect_valid         (redirect_valid),
        .ic_read_done           (ic_read_done),
        .ic_read_data           (ic_read_data),
        .ls_req                 (ls_req),
        .ls_write               (ls_write),
        .ls_index               (ls_index),
        .ls_wmask               (ls_wmask),
        .ls_wdata               (ls_wdata),
        .ls_done                (ls_done),
        .ls_rdata               (ls_rdata),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned checks;
    int unsigned failures;
    int unsigned cyc;
    int unsigned ce_cnt;
    int unsigned last_ce_cyc;
    int unsigned last_done_cyc;
    int unsigned force_lat;
    bit          busy;

    logic [63:0] ddr_mem [logic [IW-1:0]];
    logic [63:0] ref_mem [logic [IW-1:0]];
    cmd_t        exp_q [$];

    bit            last_src;
    logic [63:0]   exp_ls_rdata;
    logic [LW-1:0] exp_ic_data;

    function automatic logic [63:0] rd_ddr(input logic [IW-1:0] i);
        return ddr_mem.exists(i) ? ddr_mem[i] : {45'd0, i};
    endfunction

    function automatic logic [63:0] rd_ref(input logic [IW-1:0] i);
        return ref_mem.exists(i) ? ref_mem[i] : {45'd0, i};
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [IW-1:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = rd_ref(base + IW'(k));
        return l;
    endfunction

    // DDR responder: accepts a command on chip_enable, answers after a latency.
    initial begin : ddr_model
        cmd_t          cur;
        cmd_t          seen;
        int unsigned   cnt;
        bit            finishing;
        bit            stable_ok;
        bit            rst_hit;
        logic [LW-1:0] line;
        logic [IW-1:0] a;
        busy = 1'b0; finishing = 1'b0; stable_ok = 1'b1; rst_hit = 1'b0; cnt = 0;
        cur = '0;
        ddr_ready = 1'b1;
        ddr_operation_done = 1'b0;
        ddr_opload_read_data = '0;
        ddr_pc_read_inst = '0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            ddr_operation_done = 1'b0;
            ddr_opload_read_data = {$urandom(), $urandom()};
            for (int w = 0; w < LW / 64; w++) line[w*64 +: 64] = {$urandom(), $urandom()};
            ddr_pc_read_inst = line;
            seen = '{idx: ddr_index, we: ddr_write_enable, burst: ddr_burst_mode,
                     mask: ddr_opstore_write_mask, wdata: ddr_opstore_write_data};
            if (busy && finishing) begin
                busy = 1'b0;
                finishing = 1'b0;
            end else if (busy) begin
                if (!reset_n) rst_hit = 1'b1;
                if (seen !== cur) stable_ok = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    ddr_operation_done = 1'b1;
                    ddr_opload_read_data = rd_ddr(ddr_index);
                    for (int k = 0; k < 8; k++) begin
                        a = ddr_index + IW'(k);
                        line[k*64 +: 64] = rd_ddr(a);
                    end
                    ddr_pc_read_inst = line;
                    last_done_cyc = cyc;
                    if (!rst_hit) begin
                        checks++;
                        if (!stable_ok) begin
                            failures++;
                            $display("FAIL cmd_stable: fields drifted before completion, now %h, issued %h",
                                     seen, cur);
                        end
                    end
                    if (ddr_write_enable)
                        ddr_mem[ddr_index] = (rd_ddr(ddr_index) & ~ddr_opstore_write_mask) |
                                             (ddr_opstore_write_data & ddr_opstore_write_mask);
                    finishing = 1'b1;
                end
            end
            if (ddr_chip_enable) begin
                ce_cnt++;
                last_ce_cyc = cyc;
                checks++;
                if (busy) begin
                    failures++;
                    $display("FAIL ce_while_busy: chip_enable=1 during access, required 0");
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ce_unexpected: chip_enable with command %h, none required", seen);
                end else begin
                    cur = exp_q.pop_front();
                    if (seen !== cur) begin
                        failures++;
                        $display("FAIL cmd_issue: got %h required %h", seen, cur);
                    end
                end
                busy = 1'b1; stable_ok = 1'b1; rst_hit = 1'b0; finishing = 1'b0;
                cnt = (force_lat != 0) ? force_lat : $urandom_range(1, 8);
            end
            ddr_ready = !busy;
        end
    end

    task automatic run_ops(input bit do_ls, input bit ls_we, input logic [IW-1:0] ls_idx,
                           input logic [63:0] ls_m, input logic [63:0] ls_wd,
                           input bit do_ic, input logic [IW-1:0] ic_idx);
        bit            first;
        bit            src;
        bit            ls_pend;
        bit            ic_pend;
        int unsigned   ce_before;
        int unsigned   req_cyc;
        logic [63:0]   ls_exp;
        logic [LW-1:0] ic_exp;
        ls_exp = exp_ls_rdata;
        ic_exp = exp_ic_data;
        if (do_ls && do_ic) first = (last_src == SRC_I) ? SRC_L : SRC_I;
        else first = do_ls ? SRC_L : SRC_I;
        for (int k = 0; k < 2; k++) begin
            src = (k == 0) ? first : ~first;
            if (src == SRC_L && do_ls) begin
                last_src = SRC_L;
                exp_q.push_back('{idx: ls_idx, we: ls_we, burst: 1'b0, mask: ls_m, wdata: ls_wd});
                if (ls_we) ref_mem[ls_idx] = (rd_ref(ls_idx) & ~ls_m) | (ls_wd & ls_m);
                else ls_exp = rd_ref(ls_idx);
            end else if (src == SRC_I && do_ic) begin
                last_src = SRC_I;
                exp_q.push_back('{idx: ic_idx, we: 1'b0, burst: 1'b1, mask: 64'd0, wdata: 64'd0});
                ic_exp = ref_line(ic_idx);
            end
        end
        ls_index = ls_idx; ls_write = ls_we; ls_wmask = ls_m; ls_wdata = ls_wd;
        ic_read_index = ic_idx;
        ls_req = do_ls; ic_read_req = do_ic;
        ls_pend = do_ls; ic_pend = do_ic;
        ce_before = ce_cnt;
        req_cyc = cyc;
        for (int c = 0; c < 400 && (ls_pend || ic_pend); c++) begin
            @(posedge clock);
            #2;
            if (c == 0) begin
                checks++;
                if (ce_cnt != ce_before + 1 || last_ce_cyc != req_cyc + 1) begin
                    failures++;
                    $display("FAIL grant_latency: chip_enables=%0d at cycle %0d, required 1 at cycle %0d",
                             ce_cnt - ce_before, last_ce_cyc, req_cyc + 1);
                end
            end
            if (ls_done) begin
                checks++;
                if (!ls_pend || (first == SRC_I && ic_pend) || cyc != last_done_cyc + 1) begin
                    failures++;
                    $display("FAIL ls_done_event: pending=%0d ic_pending=%0d cycle=%0d, required cycle %0d",
                             ls_pend, ic_pend, cyc, last_done_cyc + 1);
                end
                checks++;
                if (ls_rdata !== ls_exp) begin
                    failures++;
                    $display("FAIL ls_rdata: got %h required %h", ls_rdata, ls_exp);
                end
                exp_ls_rdata = ls_exp;
                ls_pend = 1'b0;
                ls_req = 1'b0;
            end
            if (ic_read_done) begin
                checks++;
                if (!ic_pend || (first == SRC_L && ls_pend) || cyc != last_done_cyc + 1) begin
                    failures++;
                    $display("FAIL ic_done_event: pending=%0d ls_pending=%0d cycle=%0d, required cycle %0d",
                             ic_pend, ls_pend, cyc, last_done_cyc + 1);
                end
                checks++;
                if (ic_read_data !== ic_exp) begin
                    failures++;
                    $display("FAIL ic_read_data: got %h required %h", ic_read_data, ic_exp);
                end
                exp_ic_data = ic_exp;
                ic_pend = 1'b0;
                ic_read_req = 1'b0;
            end
        end
        checks++;
        if (ls_pend || ic_pend) begin
            failures++;
            $display("FAIL done_timeout: ls_pending=%0d ic_pending=%0d, required 0 0", ls_pend, ic_pend);
            ls_req = 1'b0;
            ic_read_req = 1'b0;
        end
        @(posedge clock);
        #2;
        checks++;
        if (ls_done || ic_read_done) begin
            failures++;
            $display("FAIL done_width: ls_done=%0d ic_read_done=%0d after pulse, required 0 0",
                     ls_done, ic_read_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ic_read_req = 1'b0; ic_read_index = '0; redirect_valid = 1'b0;
        ls_req = 1'b0; ls_write = 1'b0; ls_index = '0; ls_wmask = '0; ls_wdata = '0;
        force_lat = 0;
        last_src = SRC_I;
        exp_ls_rdata = '0;
        exp_ic_data = '0;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if ({ic_read_done, ls_done, ddr_chip_enable, ddr_write_enable, ddr_burst_mode} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {ic_read_done, ls_done, ddr_chip_enable, ddr_write_enable, ddr_burst_mode});
        end
        checks++;
        if (ls_rdata !== 64'd0 || ic_read_data !== '0) begin
            failures++;
            $display("FAIL reset_data: ls_rdata=%h ic_read_data=%h, required 0", ls_rdata, ic_read_data);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #2;
    endtask

    task automatic test_redirect_idle();
        int unsigned ce_before;
        ce_before = ce_cnt;
        ic_read_index = 19'h48;
        ic_read_req = 1'b1;
        redirect_valid = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        ic_read_req = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clock);
        #2;
        checks++;
        if (ce_cnt != ce_before) begin
            failures++;
            $display("FAIL redirect_idle: chip_enables=%0d, required 0", ce_cnt - ce_before);
        end
    endtask

    task automatic test_redirect_wait();
        int unsigned   ce_before;
        bit            saw;
        logic [LW-1:0] held;
        held = exp_ic_data;
        last_src = SRC_I;
        exp_q.push_back('{idx: 19'h80, we: 1'b0, burst: 1'b1, mask: 64'd0, wdata: 64'd0});
        force_lat = 25;
        ce_before = ce_cnt;
        ic_read_index = 19'h80;
        ic_read_req = 1'b1;
        @(posedge clock);
        #2;
        checks++;
        if (ce_cnt != ce_before + 1) begin
            failures++;
            $display("FAIL redirect_issue: chip_enables=%0d, required 1", ce_cnt - ce_before);
        end
        repeat (10) @(posedge clock);
        #2;
        redirect_valid = 1'b1;
        ic_read_req = 1'b0;
        @(posedge clock);
        #2;
        redirect_valid = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #2;
            if (ic_read_done) saw = 1'b1;
        end
        force_lat = 0;
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL redirect_done: ic_read_done pulsed=1, required 0");
        end
        checks++;
        if (ic_read_data !== held) begin
            failures++;
            $display("FAIL redirect_data: got %h required %h", ic_read_data, held);
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL redirect_ddr_idle: ddr busy=1, required 0");
        end
    endtask

    task automatic test_reset_mid_wait();
        bit saw;
        last_src = SRC_L;
        exp_q.push_back('{idx: 19'h100, we: 1'b0, burst: 1'b0, mask: 64'd0, wdata: 64'd0});
        force_lat = 30;
        ls_index = 19'h100; ls_write = 1'b0; ls_wmask = '0; ls_wdata = '0;
        ls_req = 1'b1;
        repeat (6) @(posedge clock);
        #3;
        reset_n = 1'b0;
        ls_req = 1'b0;
        #1;
        checks++;
        if ({ic_read_done, ls_done, ddr_chip_enable, ddr_write_enable, ddr_burst_mode} !== 5'b0 ||
            ddr_index !== '0 || ddr_opstore_write_mask !== '0 || ddr_opstore_write_data !== '0) begin
            failures++;
            $display("FAIL async_reset_ctrl: ctrl=%b index=%h, required all 0",
                     {ic_read_done, ls_done, ddr_chip_enable, ddr_write_enable, ddr_burst_mode}, ddr_index);
        end
        checks++;
        if (ls_rdata !== 64'd0 || ic_read_data !== '0) begin
            failures++;
            $display("FAIL async_reset_data: ls_rdata=%h ic_read_data=%h, required 0", ls_rdata, ic_read_data);
        end
        last_src = SRC_I;
        exp_ls_rdata = '0;
        exp_ic_data = '0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 50 && busy; c++) begin
            @(posedge clock);
            #2;
            if (ls_done || ic_read_done) saw = 1'b1;
        end
        @(posedge clock);
        #2;
        if (ls_done || ic_read_done) saw = 1'b1;
        force_lat = 0;
        checks++;
        if (saw || busy) begin
            failures++;
            $display("FAIL reset_abort: done_seen=%0d ddr_busy=%0d, required 0 0", saw, busy);
        end
        run_ops(1'b1, 1'b0, 19'h100, 64'd0, 64'd0, 1'b1, 19'h40);
    endtask

    task automatic test_random();
        int unsigned   mode;
        logic [63:0]   m;
        logic [IW-1:0] li;
        logic [IW-1:0] ii;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            li = 19'h200 + IW'($urandom_range(0, 15));
            ii = {IW'($urandom_range(0, 255)) << 3};
            case ($urandom_range(0, 3))
                0: m = '1;
                1: m = 64'h0000_0000_FFFF_FFFF;
                2: m = 64'hFF00_FF00_FF00_FF00;
                default: m = {$urandom(), $urandom()};
            endcase
            run_ops(mode != 1, 1'($urandom_range(0, 1)), li, m, {$urandom(), $urandom()},
                    mode != 0, ii);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ddr_mem[19'h100] = 64'h0000_0000_DEAD_BEEF;
        ref_mem[19'h100] = 64'h0000_0000_DEAD_BEEF;
        test_reset();
        run_ops(1'b1, 1'b0, 19'h100, 64'd0, 64'd0, 1'b0, 19'h0);
        run_ops(1'b0, 1'b0, 19'h0, 64'd0, 64'd0, 1'b1, 19'h40);
        run_ops(1'b1, 1'b0, 19'h101, 64'd0, 64'd0, 1'b1, 19'h48);
        run_ops(1'b1, 1'b0, 19'h102, 64'd0, 64'd0, 1'b1, 19'h50);
        run_ops(1'b1, 1'b0, 19'h103, 64'd0, 64'd0, 1'b1, 19'h58);
        run_ops(1'b1, 1'b1, 19'h100, 64'h0000_0000_FFFF_FFFF, 64'h1234, 1'b0, 19'h0);
        run_ops(1'b1, 1'b0, 19'h100, 64'd0, 64'd0, 1'b0, 19'h0);
        test_redirect_idle();
        redirect_valid = 1'b1;
        run_ops(1'b1, 1'b0, 19'h101, 64'd0, 64'd0, 1'b0, 19'h0);
        redirect_valid = 1'b0;
        test_redirect_wait();
        run_ops(1'b1, 1'b0, 19'h100, 64'd0, 64'd0, 1'b0, 19'h0);
        test_random();
        test_reset_mid_wait();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL cmd_leftover: %0d commands never issued, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at time limit");
        $fatal(1, "time limit");
    end

endmodule
